// File: rtl/router_pkt_fifo.sv
// Packet-aware FIFO for one router output channel. Each entry carries a header tag,
// and the read side counts packet length so it can flag the final (parity) byte.
module router_pkt_fifo #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int AFULL_TH = DEPTH - 2
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              soft_reset,
   input  logic              write_enb,
   input  logic              lfd_state,
   input  logic [DATA_W-1:0] data_in,
   input  logic              read_enb,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              last_out,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic [ADDR_W:0]   fill_level,
   output logic [ADDR_W:0]   pkt_count,
   output logic              ovf_err,
   output logic              udf_err
);

   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   AFULL_L  = (ADDR_W+1)'(AFULL_TH);
   localparam logic [DATA_W-2:0] REM_ONE  = (DATA_W-1)'(1);

   // Handshake: a write is taken when write_enb && !full, a read when read_enb && !empty;
   // the popped word appears on data_out with data_valid one edge after the read accept.
   logic [DATA_W:0]   mem [DEPTH];
   logic [ADDR_W:0]   wr_ptr;
   logic [ADDR_W:0]   rd_ptr;
   logic [DATA_W-2:0] rem;
   logic [ADDR_W:0]   fill_next;
   logic [ADDR_W:0]   pkt_next;
   logic [DATA_W:0]   rd_word;
   logic              wr_acc;
   logic              rd_acc;
   logic              rd_tag;

   assign wr_acc  = write_enb && !full;
   assign rd_acc  = read_enb && !empty;
   assign rd_word = mem[rd_ptr[ADDR_W-1:0]];
   assign rd_tag  = rd_word[DATA_W];

   always_comb begin
      fill_next = fill_level;
      if (wr_acc && !rd_acc)
         fill_next = fill_level + CNT_ONE;
      else if (rd_acc && !wr_acc)
         fill_next = fill_level - CNT_ONE;
   end

   always_comb begin
      pkt_next = pkt_count;
      if ((wr_acc && lfd_state) && !(rd_acc && rd_tag))
         pkt_next = pkt_count + CNT_ONE;
      else if ((rd_acc && rd_tag) && !(wr_acc && lfd_state))
         pkt_next = pkt_count - CNT_ONE;
   end

   // Storage is never cleared; the tag bit is rewritten with every word.
   always_ff @(posedge clock) begin
      if (wr_acc)
         mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
   end

   always_ff @(posedge clock) begin
      if (!resetn || soft_reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fill_level  <= '0;
         pkt_count   <= '0;
         full        <= 1'b0;
         empty       <= 1'b1;
         almost_full <= 1'b0;
         ovf_err     <= 1'b0;
         udf_err     <= 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + CNT_ONE;
         if (rd_acc)
            rd_ptr <= rd_ptr + CNT_ONE;
         fill_level  <= fill_next;
         pkt_count   <= pkt_next;
         full        <= (fill_next == DEPTH_L);
         empty       <= (fill_next == '0);
         almost_full <= (fill_next >= AFULL_L);
         if (write_enb && full)
            ovf_err <= 1'b1;
         if (read_enb && empty)
            udf_err <= 1'b1;
      end
   end

   // A header reloads the length counter even mid-packet, so a truncated packet never gets last_out.
   always_ff @(posedge clock) begin
      if (!resetn || soft_reset) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         last_out   <= 1'b0;
         rem        <= '0;
      end else if (rd_acc) begin
         data_out   <= rd_word[DATA_W-1:0];
         data_valid <= 1'b1;
         if (rd_tag) begin
            rem      <= {1'b0, rd_word[DATA_W-1:2]} + REM_ONE;
            last_out <= 1'b0;
         end else if (rem == REM_ONE) begin
            rem      <= '0;
            last_out <= 1'b1;
         end else begin
            if (rem != '0)
               rem <= rem - REM_ONE;
            last_out <= 1'b0;
         end
      end else begin
         data_valid <= 1'b0;
         last_out   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Randomised and directed bench for router_pkt_fifo against a queue-based packet model,
// compared on every falling edge.
module tb_router_pkt_fifo;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;
   localparam int AFULL  = DEPTH - 2;

   logic              clock = 1'b0;
   logic              resetn = 1'b0;
   logic              soft_reset = 1'b0;
   logic              write_enb = 1'b0;
   logic              lfd_state = 1'b0;
   logic [DATA_W-1:0] data_in = '0;
   logic              read_enb = 1'b0;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              last_out;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic [ADDR_W:0]   fill_level;
   logic [ADDR_W:0]   pkt_count;
   logic              ovf_err;
   logic              udf_err;

   router_pkt_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
      .write_enb(write_enb), .lfd_state(lfd_state), .data_in(data_in),
      .read_enb(read_enb), .data_out(data_out), .data_valid(data_valid),
      .last_out(last_out), .full(full), .empty(empty), .almost_full(almost_full),
      .fill_level(fill_level), .pkt_count(pkt_count),
      .ovf_err(ovf_err), .udf_err(udf_err)
   );

   always #5 clock = ~clock;

   // behavioural model
   logic [DATA_W:0]   m_q[$];
   int                m_pkt = 0;
   int                m_rem = 0;
   logic [DATA_W-1:0] m_dout = '0;
   logic              m_dv = 1'b0;
   logic              m_last = 1'b0;
   logic              m_ovf = 1'b0;
   logic              m_udf = 1'b0;

   int n_pass = 0;
   int n_total = 0;
   bit chk_en = 1'b0;

   function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
      else
         n_pass++;
   endfunction

   task automatic model_edge(input bit rn, input bit sr, input bit we, input bit lfd,
                             input logic [DATA_W-1:0] din, input bit re);
      bit wacc, racc;
      logic [DATA_W:0] w;
      if (!rn || sr) begin
         m_q.delete();
         m_pkt = 0; m_rem = 0; m_dout = '0; m_dv = 0; m_last = 0; m_ovf = 0; m_udf = 0;
         return;
      end
      wacc = we && (m_q.size() < DEPTH);
      racc = re && (m_q.size() > 0);
      if (we && m_q.size() == DEPTH) m_ovf = 1;
      if (re && m_q.size() == 0) m_udf = 1;
      if (racc) begin
         w = m_q.pop_front();
         m_dout = w[DATA_W-1:0];
         m_dv = 1;
         m_last = 0;
         if (w[DATA_W]) begin
            m_pkt--;
            m_rem = int'(w[DATA_W-1:2]) + 1;
         end else if (m_rem == 1) begin
            m_last = 1;
            m_rem = 0;
         end else if (m_rem > 0) begin
            m_rem--;
         end
      end else begin
         m_dv = 0;
         m_last = 0;
      end
      if (wacc) begin
         m_q.push_back({lfd, din});
         if (lfd) m_pkt++;
      end
   endtask

   task automatic step(input bit rn, input bit sr, input bit we, input bit lfd,
                       input logic [DATA_W-1:0] din, input bit re);
      resetn = rn; soft_reset = sr; write_enb = we; lfd_state = lfd;
      data_in = din; read_enb = re;
      @(posedge clock);
      #1;
      model_edge(rn, sr, we, lfd, din, re);
   endtask

   task automatic wr(input bit lfd, input logic [DATA_W-1:0] d);
      step(1, 0, 1, lfd, d, 0);
   endtask

   task automatic rd();
      step(1, 0, 0, 0, '0, 1);
   endtask

   task automatic idle();
      step(1, 0, 0, 0, '0, 0);
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         chk("data_out", 32'(data_out), 32'(m_dout));
         chk("data_valid", 32'(data_valid), 32'(m_dv));
         chk("last_out", 32'(last_out), 32'(m_last));
         chk("fill_level", 32'(fill_level), 32'(m_q.size()));
         chk("full", 32'(full), 32'(m_q.size() == DEPTH));
         chk("empty", 32'(empty), 32'(m_q.size() == 0));
         chk("almost_full", 32'(almost_full), 32'(m_q.size() >= AFULL));
         chk("pkt_count", 32'(pkt_count), 32'(m_pkt));
         chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
         chk("udf_err", 32'(udf_err), 32'(m_udf));
      end
   end

   initial begin
      logic [DATA_W-1:0] d;
      step(0, 0, 0, 0, '0, 0);
      step(0, 0, 0, 0, '0, 0);
      chk_en = 1'b1;
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_fill", 32'(fill_level), 32'd0);
      chk("rst_dout", 32'(data_out), 32'd0);
      idle();

      // one packet: header length 3, three payload bytes, parity
      wr(1, 8'h0C); wr(0, 8'hA1); wr(0, 8'hA2); wr(0, 8'hA3); wr(0, 8'h5E);
      chk("pkt_fill5", 32'(fill_level), 32'd5);
      chk("pkt_count1", 32'(pkt_count), 32'd1);
      rd();
      chk("pkt_hdr", 32'(data_out), 32'h0C);
      chk("pkt_count0", 32'(pkt_count), 32'd0);
      rd(); rd(); rd();
      chk("pkt_a3_notlast", 32'(last_out), 32'd0);
      rd();
      chk("pkt_parity", 32'(data_out), 32'h5E);
      chk("pkt_last", 32'(last_out), 32'd1);
      idle();

      // fill to full, overflow, drain, underflow
      for (int i = 0; i < DEPTH; i++) begin
         wr(0, 8'($urandom_range(0, 255)));
         if (i == 12) chk("af_13", 32'(almost_full), 32'd0);
         if (i == 13) chk("af_14", 32'(almost_full), 32'd1);
      end
      chk("full16", 32'(full), 32'd1);
      wr(0, 8'hFF);
      chk("ovf", 32'(ovf_err), 32'd1);
      chk("ovf_fill", 32'(fill_level), 32'd16);
      for (int i = 0; i <= DEPTH; i++) rd();
      chk("udf", 32'(udf_err), 32'd1);
      chk("udf_empty", 32'(empty), 32'd1);
      step(1, 1, 0, 0, '0, 0);

      // pointer wrap
      for (int i = 0; i < 12; i++) wr(0, 8'($urandom_range(0, 255)));
      for (int i = 0; i < 12; i++) rd();
      for (int i = 0; i < 16; i++) wr(0, 8'($urandom_range(0, 255)));
      chk("wrap_full", 32'(full), 32'd1);
      for (int i = 0; i < 16; i++) rd();
      chk("wrap_empty", 32'(empty), 32'd1);

      // simultaneous read and write at fill 8
      for (int i = 0; i < 8; i++) wr(0, 8'(8'h10 + i));
      step(1, 0, 1, 0, 8'h99, 1);
      chk("rw_fill8", 32'(fill_level), 32'd8);
      for (int i = 0; i < 7; i++) rd();
      rd();
      chk("rw_order", 32'(data_out), 32'h99);
      idle();

      // soft reset mid-packet, then zero-length packet
      wr(1, 8'h08); wr(0, 8'h44);
      step(1, 1, 0, 0, '0, 0);
      chk("sr_empty", 32'(empty), 32'd1);
      chk("sr_pkt", 32'(pkt_count), 32'd0);
      chk("sr_udf", 32'(udf_err), 32'd0);
      wr(1, 8'h00); wr(0, 8'h33);
      rd(); rd();
      chk("zl_data", 32'(data_out), 32'h33);
      chk("zl_last", 32'(last_out), 32'd1);
      idle();

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         d = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 199) == 0)
            step(0, 0, 1, 1, d, 1);
         else if ($urandom_range(0, 149) == 0)
            step(1, 1, 1, 0, d, 1);
         else
            step(1, 0, $urandom_range(0, 99) < 55, $urandom_range(0, 3) == 0,
                 d, $urandom_range(0, 99) < 50);
      end
      idle();
      @(negedge clock);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
